// File: rtl/rv32i_decoder.sv
// ============================================================================
// Module   : rv32i_decoder
// Purpose  : RV32I instruction decoder: field slices, sign-extended immediate,
//            format class, illegal-encoding detect and a sticky error flag.
//            Define DECODER_REG_OUT_EN to register all decode outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32i_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        in_valid,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  funct7,
    output logic [31:0] imm,
    output logic [1:0]  imm_type,
    output logic [2:0]  fmt,
    output logic        illegal,
    output logic        illegal_sticky
);

    localparam logic [6:0] c_OPC_OP      = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] c_OPC_JALR    = 7'b1100111;
    localparam logic [6:0] c_OPC_MISC    = 7'b0001111;
    localparam logic [6:0] c_OPC_SYSTEM  = 7'b1110011;
    localparam logic [6:0] c_OPC_STORE   = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] c_OPC_LUI     = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL     = 7'b1101111;

    localparam logic [2:0] c_FMT_R   = 3'd0;
    localparam logic [2:0] c_FMT_I   = 3'd1;
    localparam logic [2:0] c_FMT_S   = 3'd2;
    localparam logic [2:0] c_FMT_B   = 3'd3;
    localparam logic [2:0] c_FMT_U   = 3'd4;
    localparam logic [2:0] c_FMT_J   = 3'd5;
    localparam logic [2:0] c_FMT_ILL = 3'd7;

    localparam logic [6:0] c_F7_ZERO = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm;
    logic [1:0]  w_imm_type;
    logic [2:0]  w_fmt;
    logic        w_illegal;
    logic        w_sticky_set;
    logic        r_illegal_sticky;

    assign w_opcode = instruction[6:0];
    assign w_rd     = instruction[11:7];
    assign w_funct3 = instruction[14:12];
    assign w_rs1    = instruction[19:15];
    assign w_rs2    = instruction[24:20];
    assign w_funct7 = instruction[31:25];

    always_comb begin
        w_fmt      = c_FMT_ILL;
        w_imm      = 32'd0;
        w_imm_type = 2'b00;
        w_illegal  = 1'b0;
        case (w_opcode)
            c_OPC_OP: begin
                w_fmt     = c_FMT_R;
                w_illegal = ((w_funct7 != c_F7_ZERO) && (w_funct7 != c_F7_ALT)) ||
                            ((w_funct7 == c_F7_ALT) && (w_funct3 != 3'b000) && (w_funct3 != 3'b101));
            end
            c_OPC_OP_IMM, c_OPC_LOAD, c_OPC_JALR, c_OPC_MISC, c_OPC_SYSTEM: begin
                w_fmt = c_FMT_I;
                w_imm = {{20{instruction[31]}}, instruction[31:20]};
                if (w_opcode == c_OPC_OP_IMM)
                    w_illegal = ((w_funct3 == 3'b001) && (w_funct7 != c_F7_ZERO)) ||
                                ((w_funct3 == 3'b101) && (w_funct7 != c_F7_ZERO) && (w_funct7 != c_F7_ALT));
                else if (w_opcode == c_OPC_LOAD)
                    w_illegal = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
                else if (w_opcode == c_OPC_JALR)
                    w_illegal = (w_funct3 != 3'b000);
            end
            c_OPC_STORE: begin
                w_fmt      = c_FMT_S;
                w_imm_type = 2'b01;
                w_imm      = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
                w_illegal  = (w_funct3 >= 3'b011);
            end
            c_OPC_BRANCH: begin
                w_fmt      = c_FMT_B;
                w_imm_type = 2'b10;
                w_imm      = {{19{instruction[31]}}, instruction[31], instruction[7],
                              instruction[30:25], instruction[11:8], 1'b0};
                w_illegal  = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
            end
            c_OPC_LUI, c_OPC_AUIPC: begin
                w_fmt      = c_FMT_U;
                w_imm_type = 2'b11;
                w_imm      = {instruction[31:12], 12'd0};
            end
            c_OPC_JAL: begin
                w_fmt      = c_FMT_J;
                w_imm_type = 2'b11;
                w_imm      = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                              instruction[20], instruction[30:21], 1'b0};
            end
            default: w_illegal = 1'b1;
        endcase
        // Illegal encodings never leak a partial immediate or format downstream
        if (w_illegal) begin
            w_fmt      = c_FMT_ILL;
            w_imm      = 32'd0;
            w_imm_type = 2'b00;
        end
    end

`ifdef DECODER_REG_OUT_EN
    logic [6:0]  r_opcode;
    logic [4:0]  r_rd;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [6:0]  r_funct7;
    logic [31:0] r_imm;
    logic [1:0]  r_imm_type;
    logic [2:0]  r_fmt;
    logic        r_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opcode   <= 7'd0;
            r_rd       <= 5'd0;
            r_funct3   <= 3'd0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_funct7   <= 7'd0;
            r_imm      <= 32'd0;
            r_imm_type <= 2'd0;
            r_fmt      <= c_FMT_R;
            r_illegal  <= 1'b0;
        end else if (in_valid) begin
            r_opcode   <= w_opcode;
            r_rd       <= w_rd;
            r_funct3   <= w_funct3;
            r_rs1      <= w_rs1;
            r_rs2      <= w_rs2;
            r_funct7   <= w_funct7;
            r_imm      <= w_imm;
            r_imm_type <= w_imm_type;
            r_fmt      <= w_fmt;
            r_illegal  <= w_illegal && in_valid;
        end
    end

    assign opcode   = r_opcode;
    assign rd       = r_rd;
    assign funct3   = r_funct3;
    assign rs1      = r_rs1;
    assign rs2      = r_rs2;
    assign funct7   = r_funct7;
    assign imm      = r_imm;
    assign imm_type = r_imm_type;
    assign fmt      = r_fmt;
    assign illegal  = r_illegal;
    // Registered illegal was only captured on a valid instruction
    assign w_sticky_set = r_illegal;
`else
    assign opcode   = w_opcode;
    assign rd       = w_rd;
    assign funct3   = w_funct3;
    assign rs1      = w_rs1;
    assign rs2      = w_rs2;
    assign funct7   = w_funct7;
    assign imm      = w_imm;
    assign imm_type = w_imm_type;
    assign fmt      = w_fmt;
    assign illegal  = w_illegal;
    assign w_sticky_set = in_valid && w_illegal;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_illegal_sticky <= 1'b0;
        else if (w_sticky_set)
            r_illegal_sticky <= 1'b1;
    end

    assign illegal_sticky = r_illegal_sticky;

endmodule

`default_nettype wire

// File: tb/tb_rv32i_decoder.sv
// ============================================================================
// Module   : tb_rv32i_decoder
// Purpose  : Scoreboard bench for rv32i_decoder (combinational or registered).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32i_decoder;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [1:0]  imm_type;
        logic [2:0]  fmt;
        logic        illegal;
    } dec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic        in_valid;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [1:0]  imm_type;
    logic [2:0]  fmt;
    logic        illegal;
    logic        illegal_sticky;

    int   total;
    int   bad;
    dec_t exp_q[$];

    rv32i_decoder u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instruction    (instruction),
        .in_valid       (in_valid),
        .opcode         (opcode),
        .rd             (rd),
        .funct3         (funct3),
        .rs1            (rs1),
        .rs2            (rs2),
        .funct7         (funct7),
        .imm            (imm),
        .imm_type       (imm_type),
        .fmt            (fmt),
        .illegal        (illegal),
        .illegal_sticky (illegal_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic dec_t mk(input logic [31:0] ins, input logic [31:0] i_imm,
                                input logic [1:0] i_type, input logic [2:0] i_fmt,
                                input logic i_ill);
        dec_t d;
        d.opcode   = ins[6:0];
        d.rd       = ins[11:7];
        d.funct3   = ins[14:12];
        d.rs1      = ins[19:15];
        d.rs2      = ins[24:20];
        d.funct7   = ins[31:25];
        d.imm      = i_imm;
        d.imm_type = i_type;
        d.fmt      = i_fmt;
        d.illegal  = i_ill;
        return d;
    endfunction

    function automatic dec_t observed();
        dec_t d;
        d = {opcode, rd, funct3, rs1, rs2, funct7, imm, imm_type, fmt, illegal};
        return d;
    endfunction

    // Advance to the point where outputs for the instruction just driven are valid
    task automatic settle();
`ifdef DECODER_REG_OUT_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        instruction = 32'h0000_0013;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (illegal_sticky !== 1'b0) begin
            bad++;
            $display("FAIL reset_sticky: got %b expected 0", illegal_sticky);
        end
`ifdef DECODER_REG_OUT_EN
        total++;
        if (observed() !== dec_t'(0)) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0", observed());
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sticky();
        @(negedge clk);
        instruction = 32'hFFFF_FFFF;
        in_valid = 1'b0;
        #1;
`ifndef DECODER_REG_OUT_EN
        total++;
        if (illegal !== 1'b1) begin
            bad++;
            $display("FAIL illegal_novalid: got %b expected 1", illegal);
        end
`endif
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (illegal_sticky !== 1'b0) begin
            bad++;
            $display("FAIL sticky_novalid: got %b expected 0", illegal_sticky);
        end
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
`ifdef DECODER_REG_OUT_EN
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
`endif
        #1;
        total++;
        if (illegal_sticky !== 1'b1) begin
            bad++;
            $display("FAIL sticky_set: got %b expected 1", illegal_sticky);
        end
        @(negedge clk);
        in_valid = 1'b1;
        instruction = 32'h0000_0013;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (illegal_sticky !== 1'b1) begin
            bad++;
            $display("FAIL sticky_hold: got %b expected 1", illegal_sticky);
        end
        // Async clear between edges
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (illegal_sticky !== 1'b0) begin
            bad++;
            $display("FAIL sticky_async_clear: got %b expected 0", illegal_sticky);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_decode();
        logic [31:0] ins [18];
        dec_t        ex  [18];
        dec_t        e;
        ins[0]  = 32'h003100B3; ex[0]  = mk(ins[0],  32'h0,        2'b00, 3'd0, 1'b0); // ADD
        ins[1]  = 32'h00A10093; ex[1]  = mk(ins[1],  32'd10,       2'b00, 3'd1, 1'b0); // ADDI
        ins[2]  = 32'h00312223; ex[2]  = mk(ins[2],  32'd4,        2'b01, 3'd2, 1'b0); // SW
        ins[3]  = 32'hFE208EE3; ex[3]  = mk(ins[3],  32'hFFFFFFFC, 2'b10, 3'd3, 1'b0); // BEQ -4
        ins[4]  = 32'h123450B7; ex[4]  = mk(ins[4],  32'h12345000, 2'b11, 3'd4, 1'b0); // LUI
        ins[5]  = 32'h002010EF; ex[5]  = mk(ins[5],  32'h00001002, 2'b11, 3'd5, 1'b0); // JAL
        ins[6]  = 32'h403100B3; ex[6]  = mk(ins[6],  32'h0,        2'b00, 3'd0, 1'b0); // SUB
        ins[7]  = 32'h403110B3; ex[7]  = mk(ins[7],  32'h0,        2'b00, 3'd7, 1'b1); // f7=20,f3=001
        ins[8]  = 32'h023100B3; ex[8]  = mk(ins[8],  32'h0,        2'b00, 3'd7, 1'b1); // f7=01
        ins[9]  = 32'h40315093; ex[9]  = mk(ins[9],  32'h00000403, 2'b00, 3'd1, 1'b0); // SRAI
        ins[10] = 32'h40311093; ex[10] = mk(ins[10], 32'h0,        2'b00, 3'd7, 1'b1); // SLLI bad f7
        ins[11] = 32'hFE20AEE3; ex[11] = mk(ins[11], 32'h0,        2'b00, 3'd7, 1'b1); // BRANCH f3=010
        ins[12] = 32'h00013083; ex[12] = mk(ins[12], 32'h0,        2'b00, 3'd7, 1'b1); // LOAD f3=011
        ins[13] = 32'h000090E7; ex[13] = mk(ins[13], 32'h0,        2'b00, 3'd7, 1'b1); // JALR f3=001
        ins[14] = 32'h00313223; ex[14] = mk(ins[14], 32'h0,        2'b00, 3'd7, 1'b1); // STORE f3=011
        ins[15] = 32'hFFF00093; ex[15] = mk(ins[15], 32'hFFFFFFFF, 2'b00, 3'd1, 1'b0); // ADDI -1
        ins[16] = 32'hFFFFF097; ex[16] = mk(ins[16], 32'hFFFFF000, 2'b11, 3'd4, 1'b0); // AUIPC
        ins[17] = 32'hFE312E23; ex[17] = mk(ins[17], 32'hFFFFFFFC, 2'b01, 3'd2, 1'b0); // SW -4
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            instruction = ins[i];
            in_valid = 1'b1;
            exp_q.push_back(ex[i]);
            settle();
            e = exp_q.pop_front();
            total++;
            if (observed() !== e) begin
                bad++;
                $display("FAIL decode_%0d instr=%h: got %h expected %h", i, ins[i], observed(), e);
            end
        end
    endtask

    task automatic test_back_to_back();
        dec_t e;
        for (int i = 0; i < 8; i++) begin
            logic [4:0]  r;
            logic [11:0] k;
            logic [31:0] w;
            r = 5'($urandom_range(0, 31));
            k = 12'($urandom_range(0, 4095));
            w = {k, r, 3'b000, r, 7'b0010011};
            @(negedge clk);
            instruction = w;
            in_valid = 1'b1;
            exp_q.push_back(mk(w, {{20{k[11]}}, k}, 2'b00, 3'd1, 1'b0));
            settle();
            e = exp_q.pop_front();
            total++;
            if (observed() !== e) begin
                bad++;
                $display("FAIL b2b_%0d instr=%h: got %h expected %h", i, w, observed(), e);
            end
        end
    endtask

`ifdef DECODER_REG_OUT_EN
    task automatic test_reg_hold();
        dec_t e;
        e = mk(32'h00A10093, 32'd10, 2'b00, 3'd1, 1'b0);
        @(negedge clk);
        instruction = 32'h00A10093;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        instruction = 32'h003100B3;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (observed() !== e) begin
            bad++;
            $display("FAIL reg_hold: got %h expected %h", observed(), e);
        end
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_sticky();
        test_decode();
        test_back_to_back();
`ifdef DECODER_REG_OUT_EN
        test_reg_hold();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
